alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width; shift amount uses low $clog2(XLEN) bits of SrcB.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have port: start  input  1  request to execute one operation; sampled only when busy=0.
REQ-005 SHALL have port: ALUControl  input  3  operation code produced by the ALU control decoder.
REQ-006 SHALL have port: SrcA  input  XLEN  first operand.
REQ-007 SHALL have port: SrcB  input  XLEN  second operand / shift amount source.
REQ-008 SHALL have port: busy  output  1  high while a shift is in progress; start ignored while high.
REQ-009 SHALL have port: done  output  1  one-cycle pulse marking a new valid ALUResult.
REQ-010 SHALL have port: ALUResult  output  XLEN  registered result; holds between completions.
REQ-011 SHALL have port: Zero  output  1  registered, equal to (ALUResult == 0) at all times.

Function
REQ-012 SHALL decode ALUControl: 000 add, 001 sll, 010 sub (SrcA-SrcB), 100 xor, 101 srl (logical), 110 or, 111 and, 011 reserved.
REQ-013 SHALL compute add/sub modulo 2^XLEN; carry/borrow discarded.
REQ-014 SHALL implement FSM states IDLE and SHIFT; reset state IDLE.
REQ-015 SHALL accept a request in cycle T when state=IDLE and start=1; operands and ALUControl captured at the end of T; later input changes have no effect on that operation.
REQ-016 Non-shift codes (000,010,100,110,111) SHALL register the result at end of T; done=1 and ALUResult valid in cycle T+1; state stays IDLE; busy stays 0.
REQ-017 Reserved code 011 SHALL complete as REQ-016 with ALUResult=0.
REQ-018 Shift codes with shift amount n=0 SHALL complete as REQ-016 with ALUResult=SrcA.
REQ-019 Shift codes with n>0 SHALL load SrcA into a shift register and n into a down-counter, enter SHIFT, and assert busy from T+1.
REQ-020 Each SHIFT cycle SHALL shift the register one bit (left, zero fill for sll; right, zero fill for srl) and decrement the counter.
REQ-021 On the SHIFT cycle whose counter equals 1, the edge SHALL write the final value to ALUResult, set done=1, clear busy and return to IDLE; done therefore appears in cycle T+n+1 (n=1..XLEN-1).
REQ-022 start while busy=1 SHALL be ignored and not queued.
REQ-023 start=1 in the done cycle SHALL be accepted (back-to-back operations allowed, one result per done pulse).
REQ-024 done SHALL be high for exactly one cycle per accepted operation and never otherwise.
REQ-025 ALUResult and Zero SHALL change only on the completion edge or reset.

Reset
REQ-026 rst=1 SHALL immediately force state=IDLE, busy=0, done=0, ALUResult=0, Zero=1, shift counter=0.
REQ-027 rst asserted mid-shift SHALL abort the operation with no done pulse; first start after rst release is accepted normally.

Verification
REQ-028 Bench SHALL cover: rst pulse -> busy=0, done=0, ALUResult=0, Zero=1 without waiting for a clock edge.
REQ-029 Bench SHALL cover: start, ALUControl=010, SrcA=5, SrcB=5 -> next cycle done=1, ALUResult=0, Zero=1; ALUControl=000, SrcA=FFFFFFFF, SrcB=1 -> ALUResult=0 (wrap).
REQ-030 Bench SHALL cover: start, ALUControl=001, SrcA=1, SrcB=31 -> busy 31 cycles, done at T+32, ALUResult=80000000, Zero=0.
REQ-031 Bench SHALL cover: start, ALUControl=101, SrcA=F0000000, SrcB=0x24 (n=4) -> done at T+5, ALUResult=0F000000; extra start pulses during busy produce no extra done.
REQ-032 Bench SHALL cover: start held high across a done cycle with ALUControl=110, SrcA=0F0, SrcB=00F -> second op accepted in done cycle, next done with ALUResult=0FF.
REQ-033 Bench SHALL cover: rst asserted at SHIFT cycle 3 of a 10-bit sll -> no done, ALUResult=0; subsequent and op (SrcA=FF, SrcB=0F) -> ALUResult=0F.

Source files
------------

// File: rtl/alu_exec.sv
// Multi-cycle ALU: single-cycle logic ops, bit-serial shifts (one bit per cycle).
// Result is registered one cycle after acceptance (n+1 for shifts); start is ignored while busy.
module alu_exec #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      ALUControl,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] ALUResult,
  output logic            Zero
);

  localparam int SW = $clog2(XLEN);
  localparam logic [SW-1:0] CNT_ONE = SW'(1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_AND = 3'b111;

  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] shreg_q, shreg_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic            left_q, left_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            done_q, done_d;

  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] shifted;

  assign shamt   = SrcB[SW-1:0];
  assign shifted = left_q ? (shreg_q << 1) : (shreg_q >> 1);

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          done_d = 1'b1;
          case (ALUControl)
            OP_ADD: result_d = SrcA + SrcB;
            OP_SUB: result_d = SrcA - SrcB;
            OP_XOR: result_d = SrcA ^ SrcB;
            OP_OR:  result_d = SrcA | SrcB;
            OP_AND: result_d = SrcA & SrcB;
            OP_SLL, OP_SRL: begin
              if (shamt == '0) begin
                result_d = SrcA;
              end else begin
                // Defer completion: the shift engine owns the operation from here.
                done_d  = 1'b0;
                shreg_d = SrcA;
                cnt_d   = shamt;
                left_d  = (ALUControl == OP_SLL);
                state_d = S_SHIFT;
              end
            end
            default: result_d = '0;
          endcase
        end
      end
      S_SHIFT: begin
        shreg_d = shifted;
        cnt_d   = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          result_d = shifted;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign busy      = (state_q == S_SHIFT);
  assign done      = done_q;
  assign ALUResult = result_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed plus random checks of alu_exec against a plain-arithmetic reference model.
module tb_alu_exec;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        busy;
  logic        done;
  logic [31:0] ALUResult;
  logic        Zero;

  int total = 0;
  int bad   = 0;

  alu_exec #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .busy       (busy),
    .done       (done),
    .ALUResult  (ALUResult),
    .Zero       (Zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = int'(b[4:0]);
    case (c)
      3'd0:    return a + b;
      3'd1:    return a << n;
      3'd2:    return a - b;
      3'd4:    return a ^ b;
      3'd5:    return a >> n;
      3'd6:    return a | b;
      3'd7:    return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] c, input logic [31:0] b);
    if ((c == 3'd1 || c == 3'd5) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
    return 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, scramble inputs afterwards, and verify timing and result.
  task automatic run_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b, input bit poke);
    logic [31:0] exp;
    logic [31:0] prev;
    int          lat;
    int          k;
    exp  = model(c, a, b);
    lat  = latency(c, b);
    prev = ALUResult;
    ALUControl = c; SrcA = a; SrcB = b; start = 1'b1;
    step();
    start = 1'b0;
    ALUControl = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
    k = 1;
    while (k <= 40 && !done) begin
      check("busy_during_shift", 32'(busy), 32'd1);
      check("result_hold", ALUResult, prev);
      if (poke) start = 1'($urandom);
      step();
      k++;
    end
    start = 1'b0;
    check("done_latency", 32'(k), 32'(lat));
    check("result", ALUResult, exp);
    check("zero", 32'(Zero), 32'(exp == 32'd0));
    check("busy_at_done", 32'(busy), 32'd0);
    step();
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    logic [2:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    rst = 1'b0; start = 1'b0; ALUControl = 3'd0; SrcA = '0; SrcB = '0;
    #2 rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", ALUResult, 32'd0);
    check("rst_zero", 32'(Zero), 32'd1);
    step();
    rst = 1'b0;
    step();

    run_op(3'd2, 32'd5, 32'd5, 1'b0);
    run_op(3'd0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op(3'd1, 32'd1, 32'd31, 1'b0);
    run_op(3'd5, 32'hF000_0000, 32'h24, 1'b1);
    run_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    run_op(3'd1, 32'hDEAD_BEEF, 32'h40, 1'b0);
    run_op(3'd5, 32'h8000_0001, 32'd1, 1'b0);

    // Back-to-back: second request held through the done cycle of a 2-bit shift.
    ALUControl = 3'd1; SrcA = 32'd3; SrcB = 32'd2; start = 1'b1;
    step();
    check("b2b_busy", 32'(busy), 32'd1);
    ALUControl = 3'd6; SrcA = 32'h0F0; SrcB = 32'h00F;
    step();
    check("b2b_busy2", 32'(busy), 32'd1);
    step();
    check("b2b_done1", 32'(done), 32'd1);
    check("b2b_result1", ALUResult, 32'hC);
    step();
    start = 1'b0;
    check("b2b_done2", 32'(done), 32'd1);
    check("b2b_result2", ALUResult, 32'h0FF);
    step();
    check("b2b_done_drop", 32'(done), 32'd0);

    // Asynchronous reset in the middle of a 10-bit shift.
    ALUControl = 3'd1; SrcA = 32'h0000_0003; SrcB = 32'd10; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_result", ALUResult, 32'd0);
    check("mid_rst_zero", 32'(Zero), 32'd1);
    step();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      check("no_done_after_abort", 32'(done), 32'd0);
      check("result_after_abort", ALUResult, 32'd0);
      step();
    end
    run_op(3'd7, 32'hFF, 32'h0F, 1'b0);

    for (int i = 0; i < 40; i++) begin
      c = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b[4:0] = 5'd0;
      if ($urandom_range(0, 5) == 0) b = a;
      run_op(c, a, b, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
